sd_spi_responder: RTL



---
 rtl/sd_pkg.sv | 25 ++
 rtl/sd_spi_responder_if.sv | 10 +
 rtl/sd_crc7.sv | 17 +
 rtl/sd_spi_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - SD-over-SPI command constants, R1 layout and responder FSM states
package sd_pkg;

    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;

    localparam int R1_IDLE    = 0;
    localparam int R1_ILLEGAL = 2;
    localparam int R1_CRC     = 3;

    // Byte counter value held while the sixth (CRC) frame byte is arriving
    localparam logic [2:0] FRAME_LAST = 3'd5;
    localparam logic [2:0] R1_BYTES   = 3'd1;
    localparam logic [2:0] R7_BYTES   = 3'd5;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_CMD  = 2'd1,
        ST_NCR  = 2'd2,
        ST_RESP = 2'd3
    } sd_state_e;

endpackage

// File: rtl/sd_spi_responder_if.sv
// rtl/sd_spi_responder_if.sv - SPI pin bundle between SD host and card
interface sd_spi_responder_if;
    logic sclk;
    logic mosi;
    logic ss;
    logic miso;

    modport master (output sclk, output mosi, output ss, input miso);
    modport slave  (input sclk, input mosi, input ss, output miso);
endinterface

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - combinational CRC7 (x^7+x^3+1, init 0) over a 40-bit command body
module sd_crc7 (
    input  logic [39:0] data_i,
    output logic [6:0]  crc_o
);
    always_comb begin
        logic [6:0] c;
        logic       fb;
        c  = '0;
        fb = 1'b0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ data_i[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        crc_o = c;
    end
endmodule

// File: rtl/sd_spi_responder.sv
// rtl/sd_spi_responder.sv - SPI-mode SD card responder: frame capture, CRC7, init FSM, R1/R7 replies
module sd_spi_responder
    import sd_pkg::*;
#(
    parameter int NCR_BYTES  = 1,
    parameter int INIT_COUNT = 2,
    parameter int CHECK_CRC  = 1
) (
    input  logic                clk,
    input  logic                rst,
    sd_spi_responder_if.slave   spi,
    output logic                cmd_valid,
    output logic [5:0]          cmd_index,
    output logic [31:0]         cmd_arg,
    output logic                crc_err,
    output logic                in_idle
);
    localparam logic [3:0] NCR4  = 4'(NCR_BYTES);
    localparam logic [3:0] INIT4 = 4'(INIT_COUNT);

    logic [1:0]  sclk_s_q, mosi_s_q, ss_s_q;
    logic        sclk_q, ss_q;
    logic [6:0]  rx_sr_q;
    logic [2:0]  rx_bit_q, tx_bit_q, byte_cnt_q, resp_left_q;
    logic [7:0]  tx_sr_q, next_tx_q;
    logic        miso_q;
    sd_state_e   state_q;
    logic [39:0] frame_q, resp_q;
    logic [3:0]  ncr_left_q, acmd_cnt_q;
    logic        acmd_q, in_idle_q, cmd_valid_q, crc_err_q;
    logic [5:0]  cmd_index_q;
    logic [31:0] cmd_arg_q;

    logic        rise, fall, ss_high, ss_assert, byte_done, crc_bad;
    logic [7:0]  rx_byte;
    logic [6:0]  crc_calc;
    logic [5:0]  idx;
    logic [31:0] arg;

    logic        idle_d, acmd_d;
    logic [3:0]  cnt_d;
    logic [39:0] resp_d;
    logic [2:0]  resp_len_d;

    assign rise      = sclk_s_q[1] & ~sclk_q;
    assign fall      = ~sclk_s_q[1] & sclk_q;
    assign ss_high   = ss_s_q[1];
    assign ss_assert = ~ss_s_q[1] & ss_q;
    assign rx_byte   = {rx_sr_q, mosi_s_q[1]};
    assign byte_done = rise && (rx_bit_q == 3'd7);
    assign idx       = frame_q[37:32];
    assign arg       = frame_q[31:0];

    sd_crc7 u_crc (
        .data_i (frame_q),
        .crc_o  (crc_calc)
    );

    assign crc_bad = (CHECK_CRC != 0) && (crc_calc != rx_byte[7:1]);

    // Command decode evaluated against the sixth byte as it arrives
    always_comb begin
        logic [7:0]  r1;
        logic [31:0] tail;
        idle_d     = in_idle_q;
        acmd_d     = 1'b0;
        cnt_d      = acmd_cnt_q;
        r1         = 8'h00;
        tail       = 32'hFFFF_FFFF;
        resp_len_d = R1_BYTES;
        if (crc_bad) begin
            acmd_d     = acmd_q;
            r1[R1_CRC] = 1'b1;
        end else begin
            case (idx)
                CMD0: begin
                    idle_d = 1'b1;
                    cnt_d  = 4'd0;
                end
                CMD8: begin
                    resp_len_d = R7_BYTES;
                    tail       = {16'h0000, 4'h0, arg[11:8], arg[7:0]};
                end
                CMD55: acmd_d = 1'b1;
                CMD41: begin
                    if (acmd_q) begin
                        if (acmd_cnt_q != 4'hF) cnt_d = acmd_cnt_q + 4'd1;
                        if (cnt_d >= INIT4) idle_d = 1'b0;
                    end else begin
                        r1[R1_ILLEGAL] = 1'b1;
                    end
                end
                default: r1[R1_ILLEGAL] = 1'b1;
            endcase
        end
        r1[R1_IDLE] = idle_d;
        resp_d      = {r1, tail};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s_q    <= 2'b00;
            mosi_s_q    <= 2'b11;
            ss_s_q      <= 2'b11;
            sclk_q      <= 1'b0;
            ss_q        <= 1'b1;
            rx_sr_q     <= '0;
            rx_bit_q    <= '0;
            tx_bit_q    <= '0;
            byte_cnt_q  <= '0;
            resp_left_q <= '0;
            tx_sr_q     <= 8'hFF;
            next_tx_q   <= 8'hFF;
            miso_q      <= 1'b1;
            state_q     <= ST_HUNT;
            frame_q     <= '0;
            resp_q      <= '1;
            ncr_left_q  <= '0;
            acmd_cnt_q  <= '0;
            acmd_q      <= 1'b0;
            in_idle_q   <= 1'b1;
            cmd_valid_q <= 1'b0;
            crc_err_q   <= 1'b0;
            cmd_index_q <= '0;
            cmd_arg_q   <= '0;
        end else begin
            sclk_s_q    <= {sclk_s_q[0], spi.sclk};
            mosi_s_q    <= {mosi_s_q[0], spi.mosi};
            ss_s_q      <= {ss_s_q[0], spi.ss};
            sclk_q      <= sclk_s_q[1];
            ss_q        <= ss_s_q[1];
            cmd_valid_q <= 1'b0;
            if (ss_high) begin
                rx_bit_q   <= '0;
                tx_bit_q   <= '0;
                byte_cnt_q <= '0;
                tx_sr_q    <= 8'hFF;
                next_tx_q  <= 8'hFF;
                state_q    <= ST_HUNT;
            end else begin
                if (ss_assert) miso_q <= tx_sr_q[7];
                if (rise) begin
                    rx_sr_q  <= rx_byte[6:0];
                    rx_bit_q <= rx_bit_q + 3'd1;
                    if (byte_done) begin
                        frame_q <= {frame_q[31:0], rx_byte};
                        case (state_q)
                            ST_HUNT: begin
                                next_tx_q <= 8'hFF;
                                if (rx_byte[7:6] == 2'b01) begin
                                    state_q    <= ST_CMD;
                                    byte_cnt_q <= 3'd1;
                                end
                            end
                            ST_CMD: begin
                                next_tx_q <= 8'hFF;
                                if (byte_cnt_q == FRAME_LAST) begin
                                    cmd_valid_q <= 1'b1;
                                    cmd_index_q <= idx;
                                    cmd_arg_q   <= arg;
                                    crc_err_q   <= crc_bad;
                                    in_idle_q   <= idle_d;
                                    acmd_q      <= acmd_d;
                                    acmd_cnt_q  <= cnt_d;
                                    resp_q      <= resp_d;
                                    resp_left_q <= resp_len_d - 3'd1;
                                    ncr_left_q  <= NCR4;
                                    state_q     <= ST_NCR;
                                end else begin
                                    byte_cnt_q <= byte_cnt_q + 3'd1;
                                end
                            end
                            ST_NCR: begin
                                if (ncr_left_q == 4'd1) begin
                                    next_tx_q <= resp_q[39:32];
                                    resp_q    <= {resp_q[31:0], 8'hFF};
                                    state_q   <= ST_RESP;
                                end else begin
                                    next_tx_q  <= 8'hFF;
                                    ncr_left_q <= ncr_left_q - 4'd1;
                                end
                            end
                            ST_RESP: begin
                                if (resp_left_q == 3'd0) begin
                                    next_tx_q <= 8'hFF;
                                    state_q   <= ST_HUNT;
                                end else begin
                                    next_tx_q   <= resp_q[39:32];
                                    resp_q      <= {resp_q[31:0], 8'hFF};
                                    resp_left_q <= resp_left_q - 3'd1;
                                end
                            end
                            default: state_q <= ST_HUNT;
                        endcase
                    end
                end else if (fall) begin
                    tx_bit_q <= tx_bit_q + 3'd1;
                    // The 8th fall hands over to the next byte so its MSB leads the next rise
                    if (tx_bit_q == 3'd7) begin
                        tx_sr_q <= next_tx_q;
                        miso_q  <= next_tx_q[7];
                    end else begin
                        tx_sr_q <= {tx_sr_q[6:0], 1'b1};
                        miso_q  <= tx_sr_q[6];
                    end
                end
            end
        end
    end

    assign spi.miso  = miso_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_index = cmd_index_q;
    assign cmd_arg   = cmd_arg_q;
    assign crc_err   = crc_err_q;
    assign in_idle   = in_idle_q;

endmodule
